round_robin_arb_tree: RTL and testbench
=======================================

# round_robin_arb_tree

Parameterizable round-robin arbiter with data multiplexing that merges `NumIn` valid/ready request streams onto one output stream. Each stream carries a `DataWidth` payload. It is the second-stage per-bank arbiter of the TCDM switch network, sitting between the parallel switch networks and each memory bank. It provides the following:
- Fair round-robin or externally driven priority.
- Optional lock-in of a stalled decision, for AXI-style valid stability.
- Index reporting for response routing.

## Interface
- `NumIn`, default 4: number of request inputs; must be ≥ 1.
- `DataWidth`, default 32: payload width in bits.
- `ExtPrio`, default 0: 1 = priority pointer taken from `rr_i`; 0 = internal pointer.
- `AxiVldRdy`, default 1: 1 = `gnt_o` is asserted only to the selected input and only while `gnt_i` is high.
- `LockIn`, default 1: 1 = a presented but ungranted decision is held until its handshake.
- `IdxWidth`, derived as max(1, ceil(log2(NumIn))): pointer and index width.

Ports:
- `clk_i`, in, 1: clock, rising edge.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `flush_i`, in, 1: synchronous clear of pointer and lock.
- `rr_i`, in, IdxWidth: external priority pointer; used only when `ExtPrio`=1.
- `req_i`, in, NumIn: per-input valid.
- `gnt_o`, out, NumIn: per-input ready.
- `data_i`, in, NumIn×DataWidth: per-input payload.
- `req_o`, out, 1: output valid.
- `gnt_i`, in, 1: output ready.
- `data_o`, out, DataWidth: selected payload.
- `idx_o`, out, IdxWidth: index of the selected input.

## Operation
- The pointer `ptr` is `rr_i` when `ExtPrio`=1; otherwise it is the internal register `rr_q`.
- **Selection (unlocked):** `idx_o` is the first `i` with `req_i[i]`=1, searching cyclically `ptr`, `ptr`+1, …, `NumIn`−1, 0, …, `ptr`−1. If no input requests, `idx_o` = `ptr` (clamped to `NumIn`−1).
- `req_o` = OR of `req_i`, except during lock (see below).
- `data_o` = `data_i[idx_o]`.
- **Grant:** `gnt_o[i]` = `gnt_i` AND (`i` == `idx_o`) AND `req_o`. All other bits are 0. With `AxiVldRdy`=0, `gnt_o[idx_o]` = `gnt_i` regardless of `req_o`.
- **Handshake:** a handshake occurs when `req_o` AND `gnt_i`.
- **Pointer update (`ExtPrio`=0):**
  - On a handshake, `rr_q` ← `idx_o`+1, wrapping `NumIn`−1 → 0.
  - With no handshake, `rr_q` holds.
  - `flush_i` overrides: `rr_q` ← 0.
- **Lock-in (`LockIn`=1):**
  - If `req_o`=1 and `gnt_i`=0, `lock_q` ← 1 and `lock_idx_q` ← `idx_o`.
  - While `lock_q`=1, `idx_o` = `lock_idx_q`, and `req_o` = `req_i[lock_idx_q]`. Inputs must keep valid high once asserted, so this stays 1.
  - `lock_q` clears on the handshake cycle or on `flush_i`.
  - A new higher-priority request arriving during lock does not change the selection.
  - With `LockIn`=0, selection is recomputed every cycle.
- **NumIn == 1:** pass-through.
  - `req_o` = `req_i`, `gnt_o` = `gnt_i`, `data_o` = `data_i`, `idx_o` = 0.
  - No state.
- **Non-power-of-two NumIn:** selection uses cyclic order over valid indices only. An index ≥ `NumIn` is never produced.

## Timing
- Fully combinational from `req_i`/`data_i`/`gnt_i`/`rr_i` to outputs; zero-cycle latency.
- State consists of `rr_q`, `lock_q` and `lock_idx_q` only.
- State updates on the rising edge after the triggering cycle.
- Reset: `rr_q`=0, `lock_q`=0, `lock_idx_q`=0. With all `req_i` low, outputs are `req_o`=0, `gnt_o`=0, `idx_o`=0.
- Reset asserted mid-operation immediately clears state. This includes an active lock, which is discarded.
- `flush_i` has priority over handshake and lock-set in the same cycle.
- The same input is never granted twice in a row while another input is continuously requesting (`ExtPrio`=0).

## Test plan
1. **Reset/idle.** Reset, then `req_i`=0 → `req_o`=0, `gnt_o`=0, `idx_o`=0.
2. **Fairness.** `NumIn`=4, `req_i`=4'b1111, `gnt_i`=1 constant for 8 cycles → `idx_o` sequence 0,1,2,3,0,1,2,3. Each `gnt_o` is one-hot and matches `idx_o`. `data_o` equals the corresponding `data_i`.
3. **Skip idle inputs.**
   - Start from `rr_q`=0.
   - `req_i`=4'b1010 → `idx_o`=1; after the handshake, `rr_q`=2.
   - Next cycle → `idx_o`=3; after the handshake, `rr_q`=0.
   - Next cycle → `idx_o`=1.
4. **Lock-in.**
   - `req_i`=4'b0100, `gnt_i`=0 → `idx_o`=2.
   - Next cycle raise `req_i[0]` → `idx_o` stays 2 and `gnt_o`=0.
   - Assert `gnt_i` → `gnt_o`=4'b0100.
   - Next cycle → `idx_o`=0.
5. **External priority and flush.**
   - `ExtPrio`=1, `rr_i`=3, `req_i`=4'b1001 → `idx_o`=3.
   - `rr_i`=0 → `idx_o`=0.
   - With `ExtPrio`=0: after grants leave `rr_q`=2, pulse `flush_i` → next `req_i`=4'b1111 grants `idx_o`=0.
6. **NumIn=3, non-power-of-two.** `req_i`=3'b111 with `gnt_i`=1 → `idx_o` cycles 0,1,2,0 and never reaches 3.

Source files
------------

// File: rtl/round_robin_arb_tree_if.sv
// Valid/ready bundle for the per-bank round-robin arbiter: NumIn request
// streams on the input side, one merged stream plus its source index on the
// output side. The arbiter connects through the slave modport; the side that
// feeds requests and accepts the merged stream uses the master modport.
interface round_robin_arb_tree_if #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32,
    parameter int IdxWidth  = (NumIn > 1) ? $clog2(NumIn) : 1
);
    // Request side
    logic [NumIn-1:0]                req_i;
    logic [NumIn-1:0]                gnt_o;
    logic [NumIn-1:0][DataWidth-1:0] data_i;

    // Merged output side
    logic                            req_o;
    logic                            gnt_i;
    logic [DataWidth-1:0]            data_o;
    logic [IdxWidth-1:0]             idx_o;

    modport slave (
        input  req_i, data_i, gnt_i,
        output gnt_o, req_o, data_o, idx_o
    );

    modport master (
        output req_i, data_i, gnt_i,
        input  gnt_o, req_o, data_o, idx_o
    );
endinterface

// File: rtl/round_robin_arb_tree.sv
// Round-robin arbiter with payload multiplexing. Merges NumIn valid/ready
// streams onto one output, with an internal or external priority pointer,
// optional lock-in of a stalled decision and reporting of the winning index
// so responses can be routed back.
module round_robin_arb_tree #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32,
    parameter bit ExtPrio   = 1'b0,
    parameter bit AxiVldRdy = 1'b1,
    parameter bit LockIn    = 1'b1,
    parameter int IdxWidth  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic [IdxWidth-1:0]     rr_i,
    round_robin_arb_tree_if.slave   bus
);

    if (NumIn == 1) begin : g_pass
        // A single input needs no arbitration and no state.
        logic unused_pass;
        assign unused_pass     = ^{clk_i, rst_ni, flush_i, rr_i};
        assign bus.req_o       = bus.req_i[0];
        assign bus.gnt_o[0]    = bus.gnt_i;
        assign bus.data_o      = bus.data_i[0];
        assign bus.idx_o       = '0;
    end else begin : g_arb
        logic [IdxWidth-1:0]  rr_q, rr_d;
        logic                 lock_q, lock_d;
        logic [IdxWidth-1:0]  lock_idx_q, lock_idx_d;

        logic [IdxWidth-1:0]  sel_idx;
        logic [IdxWidth-1:0]  idx;
        logic                 req_out;
        logic                 hs;
        logic [NumIn-1:0]     gnt_out;
        logic [DataWidth-1:0] data_out;

        // Cyclic first-requester search starting at the (clamped) pointer.
        always_comb begin
            int   ptr;
            int   cand;
            logic found;
            // NOTE: every variable written here gets a value before any
            // conditional path, so no latch can be inferred.
            ptr     = ExtPrio ? int'(rr_i) : int'(rr_q);
            if (ptr > NumIn - 1) ptr = NumIn - 1;
            found   = 1'b0;
            cand    = 0;
            sel_idx = IdxWidth'(ptr);
            for (int off = 0; off < NumIn; off++) begin
                cand = ptr + off;
                if (cand >= NumIn) cand = cand - NumIn;
                for (int i = 0; i < NumIn; i++) begin
                    if (!found && (i == cand) && bus.req_i[i]) begin
                        found   = 1'b1;
                        sel_idx = IdxWidth'(i);
                    end
                end
            end
        end

        // Apply a held decision, then mux payload and steer the grant.
        always_comb begin
            idx     = sel_idx;
            req_out = |bus.req_i;
            if (LockIn && lock_q) begin
                idx     = lock_idx_q;
                req_out = 1'b0;
                for (int i = 0; i < NumIn; i++) begin
                    if (IdxWidth'(i) == lock_idx_q) req_out = bus.req_i[i];
                end
            end
            data_out = '0;
            gnt_out  = '0;
            for (int i = 0; i < NumIn; i++) begin
                if (IdxWidth'(i) == idx) begin
                    data_out   = bus.data_i[i];
                    gnt_out[i] = AxiVldRdy ? (bus.gnt_i & req_out) : bus.gnt_i;
                end
            end
        end

        assign hs = req_out & bus.gnt_i;

        // Next pointer and lock: flush wins, then handshake, then lock-set.
        always_comb begin
            rr_d       = rr_q;
            lock_d     = lock_q;
            lock_idx_d = lock_idx_q;
            if (flush_i) begin
                rr_d       = '0;
                lock_d     = 1'b0;
                lock_idx_d = '0;
            end else begin
                if (hs) begin
                    rr_d = (int'(idx) == NumIn - 1) ? '0 : idx + 1'b1;
                end
                if (LockIn) begin
                    if (hs) begin
                        lock_d = 1'b0;
                    end else if (req_out && !bus.gnt_i) begin
                        lock_d     = 1'b1;
                        lock_idx_d = idx;
                    end
                end
            end
        end

        // Arbitration state; reset discards any pending lock.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rr_q       <= '0;
                lock_q     <= 1'b0;
                lock_idx_q <= '0;
            end else begin
                // NOTE: non-blocking so every flop samples pre-edge values.
                rr_q       <= rr_d;
                lock_q     <= lock_d;
                lock_idx_q <= lock_idx_d;
            end
        end

        assign bus.req_o  = req_out;
        assign bus.gnt_o  = gnt_out;
        assign bus.data_o = data_out;
        assign bus.idx_o  = idx;
    end

endmodule

// File: tb/tb_round_robin_arb_tree.sv
// Self-checking bench for round_robin_arb_tree: a default 4-input instance,
// an external-priority instance and a 3-input instance share clock and reset.
module tb_round_robin_arb_tree;

    typedef struct packed {
        logic        req;
        logic [3:0]  gnt;
        logic [1:0]  idx;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic [3:0] req;
        logic       gin;
        logic       fl;
        logic [1:0] rr;
        logic       ereq;
        logic [3:0] egnt;
        logic [1:0] eidx;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush4, flush_e, flush3;
    logic [1:0] rr4, rr_e, rr3;

    logic [3:0][31:0] d4, d_e;
    logic [2:0][31:0] d3;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    round_robin_arb_tree_if #(.NumIn(4), .DataWidth(32), .IdxWidth(2)) bus4 ();
    round_robin_arb_tree_if #(.NumIn(4), .DataWidth(32), .IdxWidth(2)) bus_e ();
    round_robin_arb_tree_if #(.NumIn(3), .DataWidth(32), .IdxWidth(2)) bus3 ();

    round_robin_arb_tree #(.NumIn(4), .DataWidth(32)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush4), .rr_i(rr4), .bus(bus4)
    );
    round_robin_arb_tree #(.NumIn(4), .DataWidth(32), .ExtPrio(1'b1)) dut_e (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_e), .rr_i(rr_e), .bus(bus_e)
    );
    round_robin_arb_tree #(.NumIn(3), .DataWidth(32)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush3), .rr_i(rr3), .bus(bus3)
    );

    function automatic stim_t st(logic [3:0] req, logic gin, logic fl, logic [1:0] rr,
                                 logic ereq, logic [3:0] egnt, logic [1:0] eidx);
        stim_t s;
        s = '{req, gin, fl, rr, ereq, egnt, eidx};
        return s;
    endfunction

    // Reference pick for four inputs: first requester from ptr, wrapping mod 4.
    function automatic logic [1:0] rr_pick(logic [3:0] req, logic [1:0] ptr);
        logic [1:0] c;
        for (int o = 0; o < 4; o++) begin
            c = ptr + 2'(o);
            if (req[c]) return c;
        end
        return ptr;
    endfunction

    task automatic drive4(input logic [3:0] req, input logic gin, input logic fl);
        for (int i = 0; i < 4; i++) d4[i] = $urandom;
        bus4.req_i = req; bus4.gnt_i = gin; bus4.data_i = d4; flush4 = fl;
    endtask

    task automatic drive_e(input logic [3:0] req, input logic gin, input logic [1:0] rr);
        for (int i = 0; i < 4; i++) d_e[i] = $urandom;
        bus_e.req_i = req; bus_e.gnt_i = gin; bus_e.data_i = d_e; rr_e = rr;
    endtask

    task automatic drive3(input logic [2:0] req, input logic gin, input logic fl);
        for (int i = 0; i < 3; i++) d3[i] = $urandom;
        bus3.req_i = req; bus3.gnt_i = gin; bus3.data_i = d3; flush3 = fl;
    endtask

    task automatic idle_all();
        drive4(4'b0, 1'b0, 1'b0);
        drive_e(4'b0, 1'b0, 2'd0);
        drive3(3'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        idle_all();
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{1'b0, 4'b0000, 2'd0, d4[0]});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus4.req_o, bus4.gnt_o, bus4.idx_o, bus4.data_o} !== {e.req, e.gnt, e.idx, e.data}) begin
                n_err++;
                $display("FAIL reset[%0d]: got req=%b gnt=%b idx=%0d data=%h, want req=%b gnt=%b idx=%0d data=%h",
                         k, bus4.req_o, bus4.gnt_o, bus4.idx_o, bus4.data_o, e.req, e.gnt, e.idx, e.data);
            end
            @(posedge clk);
            #1 rst_n = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                drive4(4'b0100, 1'b0, 1'b0);
                exp_q.push_back('{1'b1, 4'b0000, 2'd2, d4[2]});
            end else begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
                drive4(4'b0001, 1'b1, 1'b0);
                exp_q.push_back('{1'b1, 4'b0001, 2'd0, d4[0]});
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus4.req_o, bus4.gnt_o, bus4.idx_o, bus4.data_o} !== {e.req, e.gnt, e.idx, e.data}) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got req=%b gnt=%b idx=%0d data=%h, want req=%b gnt=%b idx=%0d data=%h",
                         k, bus4.req_o, bus4.gnt_o, bus4.idx_o, bus4.data_o, e.req, e.gnt, e.idx, e.data);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_fairness();
        exp_t e;
        logic [1:0] ei;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            ei = 2'(k % 4);
            drive4(4'b1111, 1'b1, 1'b0);
            exp_q.push_back('{1'b1, 4'b0001 << ei, ei, d4[ei]});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus4.req_o, bus4.gnt_o, bus4.idx_o, bus4.data_o} !== {e.req, e.gnt, e.idx, e.data}) begin
                n_err++;
                $display("FAIL fairness[%0d]: got req=%b gnt=%b idx=%0d data=%h, want req=%b gnt=%b idx=%0d data=%h",
                         k, bus4.req_o, bus4.gnt_o, bus4.idx_o, bus4.data_o, e.req, e.gnt, e.idx, e.data);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Runs a 4-input table on dut4 (skip, lock, flush scenarios).
    task automatic test_table4(input string name, input stim_t tbl[$]);
        exp_t e;
        do_reset();
        foreach (tbl[k]) begin
            drive4(tbl[k].req, tbl[k].gin, tbl[k].fl);
            exp_q.push_back('{tbl[k].ereq, tbl[k].egnt, tbl[k].eidx, d4[tbl[k].eidx]});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus4.req_o, bus4.gnt_o, bus4.idx_o, bus4.data_o} !== {e.req, e.gnt, e.idx, e.data}) begin
                n_err++;
                $display("FAIL %s[%0d]: got req=%b gnt=%b idx=%0d data=%h, want req=%b gnt=%b idx=%0d data=%h",
                         name, k, bus4.req_o, bus4.gnt_o, bus4.idx_o, bus4.data_o, e.req, e.gnt, e.idx, e.data);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_skip();
        stim_t t[$];
        t.push_back(st(4'b1010, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0010, 2'd1));
        t.push_back(st(4'b1010, 1'b1, 1'b0, 2'd0, 1'b1, 4'b1000, 2'd3));
        t.push_back(st(4'b1010, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0010, 2'd1));
        test_table4("skip", t);
    endtask

    task automatic test_lock();
        stim_t t[$];
        t.push_back(st(4'b0100, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 2'd2));
        t.push_back(st(4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 2'd2));
        t.push_back(st(4'b0101, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0100, 2'd2));
        t.push_back(st(4'b0101, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001, 2'd0));
        test_table4("lock", t);
    endtask

    task automatic test_flush();
        stim_t t[$];
        t.push_back(st(4'b0010, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0010, 2'd1));
        t.push_back(st(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd2));
        t.push_back(st(4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 2'd2));
        t.push_back(st(4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001, 2'd0));
        t.push_back(st(4'b0100, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 2'd2));
        t.push_back(st(4'b0101, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001, 2'd0));
        t.push_back(st(4'b0010, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0010, 2'd1));
        t.push_back(st(4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001, 2'd0));
        test_table4("flush", t);
    endtask

    task automatic test_ext_prio();
        stim_t t[$];
        exp_t e;
        t.push_back(st(4'b1001, 1'b1, 1'b0, 2'd3, 1'b1, 4'b1000, 2'd3));
        t.push_back(st(4'b1001, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001, 2'd0));
        t.push_back(st(4'b1001, 1'b1, 1'b0, 2'd1, 1'b1, 4'b1000, 2'd3));
        t.push_back(st(4'b0110, 1'b1, 1'b0, 2'd3, 1'b1, 4'b0010, 2'd1));
        t.push_back(st(4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000, 2'd2));
        do_reset();
        foreach (t[k]) begin
            drive_e(t[k].req, t[k].gin, t[k].rr);
            exp_q.push_back('{t[k].ereq, t[k].egnt, t[k].eidx, d_e[t[k].eidx]});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus_e.req_o, bus_e.gnt_o, bus_e.idx_o, bus_e.data_o} !== {e.req, e.gnt, e.idx, e.data}) begin
                n_err++;
                $display("FAIL ext_prio[%0d]: got req=%b gnt=%b idx=%0d data=%h, want req=%b gnt=%b idx=%0d data=%h",
                         k, bus_e.req_o, bus_e.gnt_o, bus_e.idx_o, bus_e.data_o, e.req, e.gnt, e.idx, e.data);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_nonpow2();
        stim_t t[$];
        exp_t e;
        t.push_back(st(4'b0111, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001, 2'd0));
        t.push_back(st(4'b0111, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0010, 2'd1));
        t.push_back(st(4'b0111, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0100, 2'd2));
        t.push_back(st(4'b0111, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001, 2'd0));
        t.push_back(st(4'b0101, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0100, 2'd2));
        t.push_back(st(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0));
        t.push_back(st(4'b0100, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0100, 2'd2));
        do_reset();
        foreach (t[k]) begin
            drive3(t[k].req[2:0], t[k].gin, t[k].fl);
            exp_q.push_back('{t[k].ereq, t[k].egnt, t[k].eidx, d3[t[k].eidx]});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus3.req_o, 1'b0, bus3.gnt_o, bus3.idx_o, bus3.data_o} !== {e.req, e.gnt, e.idx, e.data}) begin
                n_err++;
                $display("FAIL nonpow2[%0d]: got req=%b gnt=%b idx=%0d data=%h, want req=%b gnt=%b idx=%0d data=%h",
                         k, bus3.req_o, bus3.gnt_o, bus3.idx_o, bus3.data_o, e.req, e.gnt, e.idx, e.data);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Random traffic against a behavioural model of pointer and lock; a
    // stalled request is held high until it is granted.
    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] req, egnt;
        logic [1:0] rr_m, lidx_m, eidx;
        logic       lock_m, gin, ereq;
        do_reset();
        rr_m = 2'd0; lidx_m = 2'd0; lock_m = 1'b0;
        req = 4'($urandom_range(0, 15));
        for (int k = 0; k < 60; k++) begin
            gin = ($urandom_range(0, 3) != 0);
            if (lock_m) begin
                eidx = lidx_m;
                ereq = req[lidx_m];
            end else begin
                eidx = rr_pick(req, rr_m);
                ereq = |req;
            end
            egnt = (ereq && gin) ? (4'b0001 << eidx) : 4'b0000;
            drive4(req, gin, 1'b0);
            exp_q.push_back('{ereq, egnt, eidx, d4[eidx]});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus4.req_o, bus4.gnt_o, bus4.idx_o, bus4.data_o} !== {e.req, e.gnt, e.idx, e.data}) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got req=%b gnt=%b idx=%0d data=%h, want req=%b gnt=%b idx=%0d data=%h",
                         k, bus4.req_o, bus4.gnt_o, bus4.idx_o, bus4.data_o, e.req, e.gnt, e.idx, e.data);
            end
            if (ereq && gin) begin
                rr_m   = eidx + 2'd1;
                lock_m = 1'b0;
            end else if (ereq) begin
                lock_m = 1'b1;
                lidx_m = eidx;
            end
            req = (req & ~egnt) | 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rr4 = 2'd0;
        rr3 = 2'd0;
        test_reset();
        test_reset_mid();
        test_fairness();
        test_skip();
        test_lock();
        test_ext_prio();
        test_flush();
        test_nonpow2();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_err);
        $fatal(1);
    end

endmodule
